// File: rtl/counter_mod_updown_if.sv
// Control and status bundle for counter_mod_updown.
// The master side drives the controls; the counter (slave) drives the status.
interface counter_mod_updown_if #(
  parameter int WIDTH = 4
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             up_down;
  logic [WIDTH-1:0] counter_out;
  logic             terminal;
  logic             wrapped;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, load, load_value, enable, up_down,
    input  counter_out, terminal, wrapped, overflow, underflow
  );

  modport slave (
    input  clear, load, load_value, enable, up_down,
    output counter_out, terminal, wrapped, overflow, underflow
  );
endinterface

// File: rtl/counter_mod_updown.sv
// Up/down counter over 0..MAX_COUNT with optional prescaler, wrap or saturate
// at the range ends, a one-cycle wrap pulse and sticky overflow/underflow flags.
module counter_mod_updown #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter bit SATURATE  = 1'b0,
  parameter int PRESCALE  = 1
) (
  input  logic               clock,
  input  logic               reset,
  counter_mod_updown_if.slave bus
);

  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_COUNT);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("counter_mod_updown: WIDTH must be at least 2");
  end
  if (MAX_COUNT < 1 || MAX_COUNT >= 2**WIDTH) begin : g_bad_max
    $error("counter_mod_updown: MAX_COUNT must lie in 1..2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_mod_updown: PRESCALE must be at least 1");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             at_top, at_bot, step;

  // Loaded values beyond the range are pinned to the top of the range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  assign at_top = (cnt_q == MAX_V);
  assign at_bot = (cnt_q == '0);
  assign step   = bus.enable && (pre_q == PRE_LAST);

  always_comb begin
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (bus.clear) begin
      cnt_d = '0;
      pre_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (bus.load) begin
      cnt_d = clamp_load(bus.load_value);
      pre_d = '0;
    end else if (bus.enable) begin
      if (!step) begin
        pre_d = pre_q + 1'b1;
      end else begin
        pre_d = '0;
        if (bus.up_down) begin
          if (!at_top) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
            if (!SATURATE) begin
              cnt_d  = '0;
              wrap_d = 1'b1;
            end
          end
        end else begin
          if (!at_bot) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            unf_d = 1'b1;
            if (!SATURATE) begin
              cnt_d  = MAX_V;
              wrap_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      pre_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Terminal tracks the live direction input, not the registered one.
  assign bus.counter_out = cnt_q;
  assign bus.terminal    = bus.up_down ? at_top : at_bot;
  assign bus.wrapped     = wrap_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule
